// File: rtl/mem_io_responder_pkg.sv
// Shared constants and decode helper for the memory-bus responder.
// IO_RX_EN (optional) builds the RX byte path in mem_io_responder.
package mem_io_responder_pkg;

  localparam int BYTE_W = 8;
  localparam int WORD_W = 32;

  localparam logic [1:0]  IO_REGION    = 2'b11;
  localparam logic [17:0] IO_DATA_ADDR = 18'h30000;
  localparam logic [17:0] IO_STAT_ADDR = 18'h30004;

  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } bus_rw_e;

  localparam int STAT_TX_FULL     = 0;
  localparam int STAT_RX_NONEMPTY = 1;
  localparam int STAT_OVERFLOW    = 2;

  typedef enum logic [1:0] {
    SEL_RAM,
    SEL_IO_DATA,
    SEL_IO_STAT,
    SEL_IO_NONE
  } bus_sel_e;

  // Only bits [17:0] take part in decode; anything above is don't-care.
  function automatic bus_sel_e decode_addr(input logic [17:0] addr);
    bus_sel_e sel;
    if (addr[17:16] != IO_REGION)  sel = SEL_RAM;
    else if (addr == IO_DATA_ADDR) sel = SEL_IO_DATA;
    else if (addr == IO_STAT_ADDR) sel = SEL_IO_STAT;
    else                           sel = SEL_IO_NONE;
    return sel;
  endfunction

endpackage

// File: rtl/mem_io_responder_if.sv
// Byte-wide memory bus between the memory controller (master) and responder.
// The IO_RX_EN option does not change this interface.
interface mem_io_responder_if;
  import mem_io_responder_pkg::*;

  logic [WORD_W-1:0] bus_addr_in;
  logic              bus_rw_in;
  logic [BYTE_W-1:0] bus_data_in;
  logic [BYTE_W-1:0] bus_data_out;
  logic              io_buffer_full;

  modport master (
    output bus_addr_in, bus_rw_in, bus_data_in,
    input  bus_data_out, io_buffer_full
  );

  modport slave (
    input  bus_addr_in, bus_rw_in, bus_data_in,
    output bus_data_out, io_buffer_full
  );

endinterface

// File: rtl/mem_io_responder_byte_fifo.sv
// Byte FIFO with binary wrapping pointers; a push while full is accepted only
// when a pop happens in the same cycle.
module byte_fifo
  import mem_io_responder_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                push,
  input  logic                pop,
  input  logic [BYTE_W-1:0]   din,
  output logic [BYTE_W-1:0]   head,
  output logic [DEPTH_LOG2:0] count,
  output logic                full,
  output logic                empty
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [BYTE_W-1:0]     mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   count_q;
  logic                  do_push;
  logic                  do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == DEPTH_CNT);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];
  assign count   = count_q;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/mem_io_responder.sv
// Responder for the byte-wide memory bus: on-chip RAM plus an IO region with a
// TX FIFO, status register and, when IO_RX_EN is defined, an RX FIFO.
module mem_io_responder
  import mem_io_responder_pkg::*;
#(
  parameter int RAM_ADDR_WIDTH  = 17,
  parameter int FIFO_DEPTH_LOG2 = 4
) (
  input  logic              clk,
  input  logic              rst,
  mem_io_responder_if.slave bus,
  output logic              tx_valid_out,
  output logic [BYTE_W-1:0] tx_data_out,
  input  logic              tx_ready_in,
  input  logic              rx_valid_in,
  input  logic [BYTE_W-1:0] rx_data_in,
  output logic              rx_ready_out
);

  localparam int CNT_W = FIFO_DEPTH_LOG2 + 1;
  localparam logic [CNT_W-1:0] NEAR_FULL = CNT_W'((1 << FIFO_DEPTH_LOG2) - 1);

  logic [BYTE_W-1:0] ram [2**RAM_ADDR_WIDTH];
  logic [RAM_ADDR_WIDTH-1:0] ram_idx;

  bus_sel_e          sel;
  logic              is_write;
  logic [BYTE_W-1:0] rd_data;
  logic [BYTE_W-1:0] status;
  logic              overflow;

  logic              tx_push;
  logic              tx_pop;
  logic [BYTE_W-1:0] tx_head;
  logic [CNT_W-1:0]  tx_count;
  logic              tx_fifo_full;
  logic              tx_empty;
  logic              tx_near_full;

  logic              rx_nonempty;
  logic [BYTE_W-1:0] rx_head_data;

  logic unused_addr;
  assign unused_addr = ^bus.bus_addr_in[WORD_W-1:18];

  assign sel      = decode_addr(bus.bus_addr_in[17:0]);
  assign is_write = (bus.bus_rw_in == WRITE);
  assign ram_idx  = bus.bus_addr_in[RAM_ADDR_WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (sel == SEL_RAM && is_write) ram[ram_idx] <= bus.bus_data_in;
  end

  assign tx_push      = (sel == SEL_IO_DATA) && is_write;
  assign tx_pop       = tx_valid_out && tx_ready_in;
  assign tx_near_full = (tx_count >= NEAR_FULL);

  byte_fifo #(.DEPTH_LOG2(FIFO_DEPTH_LOG2)) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_push),
    .pop   (tx_pop),
    .din   (bus.bus_data_in),
    .head  (tx_head),
    .count (tx_count),
    .full  (tx_fifo_full),
    .empty (tx_empty)
  );

  // Outputs are forced low while rst is high so they read 0 even before the
  // first reset edge has cleared the FIFO state.
  assign tx_valid_out       = !rst && !tx_empty;
  assign tx_data_out        = tx_valid_out ? tx_head : '0;
  assign bus.io_buffer_full = !rst && tx_near_full;

`ifdef IO_RX_EN
  logic             rx_push;
  logic             rx_pop;
  logic [CNT_W-1:0] rx_count;
  logic             rx_full;
  logic             rx_empty;
  logic             unused_rx;

  assign rx_ready_out = !rst && !rx_full;
  assign rx_push      = rx_valid_in && rx_ready_out;
  assign rx_pop       = (sel == SEL_IO_DATA) && !is_write && !rx_empty;
  assign rx_nonempty  = !rx_empty;
  assign unused_rx    = ^rx_count;

  byte_fifo #(.DEPTH_LOG2(FIFO_DEPTH_LOG2)) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_push),
    .pop   (rx_pop),
    .din   (rx_data_in),
    .head  (rx_head_data),
    .count (rx_count),
    .full  (rx_full),
    .empty (rx_empty)
  );
`else
  logic unused_rx;

  assign rx_ready_out = 1'b0;
  assign rx_nonempty  = 1'b0;
  assign rx_head_data = '0;
  assign unused_rx    = rx_valid_in ^ (^rx_data_in);
`endif

  // A push into a full FIFO is lost only when no pop frees a slot that cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (sel == SEL_IO_STAT && is_write) begin
      overflow <= 1'b0;
    end else if (tx_push && tx_fifo_full && !tx_pop) begin
      overflow <= 1'b1;
    end
  end

  always_comb begin
    status                   = '0;
    status[STAT_TX_FULL]     = tx_near_full;
    status[STAT_RX_NONEMPTY] = rx_nonempty;
    status[STAT_OVERFLOW]    = overflow;
  end

  always_comb begin
    rd_data = '0;
    case (sel)
      SEL_RAM:     rd_data = ram[ram_idx];
      SEL_IO_DATA: rd_data = rx_nonempty ? rx_head_data : '0;
      SEL_IO_STAT: rd_data = status;
      default:     rd_data = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.bus_data_out <= '0;
    end else if (!is_write) begin
      bus.bus_data_out <= rd_data;
    end
  end

endmodule
